// File: rtl/inst_axi_writer.sv
// ----------------------------------------------------------------------------
// inst_axi_writer
// AXI4 write master that drains a local instruction FIFO into a circular
// instruction window as INCR bursts of DATA_WIDTH-bit beats. One burst is in
// flight at a time: the next burst waits for the previous write response.
//
// Optional feature macro: INST_AXI_WRITER_AUTOFLUSH_EN
//   When defined, a partial burst is launched automatically after TIMEOUT
//   idle cycles with a non-empty FIFO. When undefined, partial bursts are
//   launched only by the flush input.
// ----------------------------------------------------------------------------
module inst_axi_writer #(
    parameter int                    DATA_WIDTH = 32'd64,
    parameter int                    ADDR_WIDTH = 32'd64,
    parameter int                    ID_WIDTH   = 32'd4,
    parameter int                    AXI_ID     = 32'd1,
    parameter int                    FIFO_DEPTH = 32'd16,
    parameter int                    MAX_BURST  = 32'd4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'd0),
    parameter logic [ADDR_WIDTH-1:0] ADDR_SPAN  = ADDR_WIDTH'(32'd128),
    parameter int                    TIMEOUT    = 32'd8
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic [DATA_WIDTH-1:0]     inst_data,
    input  logic                      inst_valid,
    output logic                      inst_ready,
    input  logic                      flush,

    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [ID_WIDTH-1:0]       M_AXI_AWID,
    output logic [7:0]                M_AXI_AWLEN,
    output logic [2:0]                M_AXI_AWSIZE,
    output logic [1:0]                M_AXI_AWBURST,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,

    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WLAST,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,

    input  logic [ID_WIDTH-1:0]       M_AXI_BID,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,

    output logic                      busy,
    output logic                      err,
    output logic [31:0]               sent_count
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int SIZE_VAL   = $clog2(STRB_WIDTH);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    localparam logic [ADDR_WIDTH-1:0] WIN_END = BASE_ADDR + ADDR_SPAN;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [CNT_W-1:0]        count_r;

    logic [1:0]              state_r;
    logic [1:0]              state_nxt_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [8:0]              beats_r;
    logic [8:0]              beat_cnt_r;

    logic [ADDR_WIDTH-1:0]   awaddr_r;
    logic [ID_WIDTH-1:0]     awid_r;
    logic [7:0]              awlen_r;
    logic [2:0]              awsize_r;
    logic [1:0]              awburst_r;
    logic                    awvalid_r;
    logic                    wvalid_r;
    logic [STRB_WIDTH-1:0]   wstrb_r;
    logic                    bready_r;
    logic                    busy_r;
    logic                    err_r;
    logic [31:0]             sent_count_r;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic                    full_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    aw_hs_s;
    logic                    last_beat_s;
    logic                    w_last_hs_s;
    logic                    b_hs_s;
    logic                    af_fire_s;
    logic                    flush_req_s;
    logic                    launch_s;
    logic [ADDR_WIDTH-1:0]   room_s;
    logic [ADDR_WIDTH-1:0]   lim_cnt_s;
    logic [ADDR_WIDTH-1:0]   lim_all_s;
    logic [8:0]              beats_s;
    logic [ADDR_WIDTH-1:0]   next_addr_s;
    logic                    unused_bid_s;

    // BID is not checked; folded into an intentionally unused net.
    assign unused_bid_s = ^M_AXI_BID;

    assign full_s      = (count_r == CNT_W'(FIFO_DEPTH));
    assign push_s      = inst_valid & ~full_s;
    assign pop_s       = wvalid_r & M_AXI_WREADY;
    assign aw_hs_s     = awvalid_r & M_AXI_AWREADY;
    assign last_beat_s = (beat_cnt_r == (beats_r - 9'd1));
    assign w_last_hs_s = pop_s & last_beat_s;
    assign b_hs_s      = bready_r & M_AXI_BVALID;

`ifdef INST_AXI_WRITER_AUTOFLUSH_EN
    localparam int AF_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [AF_W-1:0] af_cnt_r;

    // Idle timer: counts IDLE cycles with pending data, saturating at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            af_cnt_r <= {AF_W{1'b0}};
        end else if (push_s || launch_s) begin
            af_cnt_r <= {AF_W{1'b0}};
        end else if ((state_r == S_IDLE) && (count_r != {CNT_W{1'b0}}) &&
                     (af_cnt_r != AF_W'(TIMEOUT))) begin
            af_cnt_r <= af_cnt_r + AF_W'(1'b1);
        end else begin
            af_cnt_r <= af_cnt_r;
        end
    end

    assign af_fire_s = (state_r == S_IDLE) && (af_cnt_r == AF_W'(TIMEOUT)) &&
                       (count_r != {CNT_W{1'b0}});
`else
    assign af_fire_s = 1'b0;
`endif

    assign flush_req_s = flush | af_fire_s;

    assign launch_s = (state_r == S_IDLE) &&
                      ((32'(count_r) >= 32'(MAX_BURST)) ||
                       (flush_req_s && (count_r != {CNT_W{1'b0}})));

    // Burst length: limited by FIFO occupancy, MAX_BURST and distance to window end.
    always_comb begin
        room_s    = (WIN_END - addr_r) >> SIZE_VAL;
        lim_cnt_s = (ADDR_WIDTH'(count_r) < ADDR_WIDTH'(MAX_BURST)) ?
                    ADDR_WIDTH'(count_r) : ADDR_WIDTH'(MAX_BURST);
        lim_all_s = (lim_cnt_s < room_s) ? lim_cnt_s : room_s;
        beats_s   = 9'(lim_all_s);
    end

    // Window pointer after the current burst, wrapping at the window end.
    always_comb begin
        next_addr_s = addr_r + (ADDR_WIDTH'(beats_r) << SIZE_VAL);
        if (next_addr_s == WIN_END) begin
            next_addr_s = BASE_ADDR;
        end else begin
            next_addr_s = next_addr_s;
        end
    end

    // Next-state logic of the burst FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (launch_s) state_nxt_s = S_ADDR;
                else          state_nxt_s = S_IDLE;
            end
            S_ADDR: begin
                if (aw_hs_s) state_nxt_s = S_DATA;
                else         state_nxt_s = S_ADDR;
            end
            S_DATA: begin
                if (w_last_hs_s) state_nxt_s = S_RESP;
                else             state_nxt_s = S_DATA;
            end
            S_RESP: begin
                if (b_hs_s) state_nxt_s = S_IDLE;
                else        state_nxt_s = S_RESP;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM state register and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != S_IDLE);
        end
    end

    // FIFO storage; contents need no reset because WDATA is gated by WVALID.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= inst_data;
        end else begin
            fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            else        wr_ptr_r <= wr_ptr_r;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            else        rd_ptr_r <= rd_ptr_r;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Write-address channel: fields latched at launch, held until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awvalid_r <= 1'b0;
            awaddr_r  <= BASE_ADDR;
            awid_r    <= {ID_WIDTH{1'b0}};
            awlen_r   <= 8'd0;
            awsize_r  <= 3'd0;
            awburst_r <= 2'd0;
            beats_r   <= 9'd0;
        end else if (launch_s) begin
            awvalid_r <= 1'b1;
            awaddr_r  <= addr_r;
            awid_r    <= ID_WIDTH'(AXI_ID);
            awlen_r   <= 8'(beats_s - 9'd1);
            awsize_r  <= 3'(SIZE_VAL);
            awburst_r <= 2'b01;
            beats_r   <= beats_s;
        end else if (aw_hs_s) begin
            awvalid_r <= 1'b0;
        end else begin
            awvalid_r <= awvalid_r;
        end
    end

    // Write-data channel: valid from AW handshake until the last beat is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wvalid_r   <= 1'b0;
            wstrb_r    <= {STRB_WIDTH{1'b0}};
            beat_cnt_r <= 9'd0;
        end else if (aw_hs_s) begin
            wvalid_r   <= 1'b1;
            wstrb_r    <= {STRB_WIDTH{1'b1}};
            beat_cnt_r <= 9'd0;
        end else if (w_last_hs_s) begin
            wvalid_r   <= 1'b0;
            beat_cnt_r <= 9'd0;
        end else if (pop_s) begin
            beat_cnt_r <= beat_cnt_r + 9'd1;
        end else begin
            wvalid_r   <= wvalid_r;
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Write-response channel, sticky error, completed-beat count and window pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bready_r     <= 1'b0;
            err_r        <= 1'b0;
            sent_count_r <= 32'd0;
            addr_r       <= BASE_ADDR;
        end else if (w_last_hs_s) begin
            bready_r <= 1'b1;
        end else if (b_hs_s) begin
            bready_r     <= 1'b0;
            err_r        <= err_r | (M_AXI_BRESP != 2'b00);
            sent_count_r <= sent_count_r + 32'(beats_r);
            addr_r       <= next_addr_s;
        end else begin
            bready_r <= bready_r;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign inst_ready    = ~full_s;
    assign M_AXI_AWADDR  = awaddr_r;
    assign M_AXI_AWID    = awid_r;
    assign M_AXI_AWLEN   = awlen_r;
    assign M_AXI_AWSIZE  = awsize_r;
    assign M_AXI_AWBURST = awburst_r;
    assign M_AXI_AWVALID = awvalid_r;
    assign M_AXI_WDATA   = wvalid_r ? fifo_mem_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
    assign M_AXI_WSTRB   = wstrb_r;
    assign M_AXI_WLAST   = wvalid_r & last_beat_s;
    assign M_AXI_WVALID  = wvalid_r;
    assign M_AXI_BREADY  = bready_r;
    assign busy          = busy_r;
    assign err           = err_r;
    assign sent_count    = sent_count_r;

endmodule

// File: doc/inst_axi_writer.md
# inst_axi_writer

AXI4 write master that pushes instructions from a host-side producer into an `InstReceiver` slave. Instructions are buffered in a local FIFO and issued as INCR bursts of 64-bit beats to a circular instruction window. Each burst waits for its write response before the next one starts. The block sits on the control-processor side of the TPU instruction path and is the initiator paired with `InstReceiver`'s AXI write port.

## Interface
- `DATA_WIDTH`, 64, beat/instruction width; STRB_WIDTH = DATA_WIDTH/8
- `ADDR_WIDTH`, 64, AXI address width
- `ID_WIDTH`, 4, AXI ID width
- `AXI_ID`, 1, constant AWID driven on every burst
- `FIFO_DEPTH`, 16, local instruction buffer entries (power of 2)
- `MAX_BURST`, 4, maximum beats per burst (1..256)
- `BASE_ADDR`, 0, byte address of window start (aligned to STRB_WIDTH)
- `ADDR_SPAN`, 128, window size in bytes (multiple of STRB_WIDTH)
- `TIMEOUT`, 8, idle cycles before auto-flush (only with macro)

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `inst_data`  in  DATA_WIDTH  instruction to send
- `inst_valid`  in  1  producer has an instruction
- `inst_ready`  out  1  FIFO not full; push when `inst_valid & inst_ready`
- `flush`  in  1  issue a partial burst if the FIFO is non-empty
- `M_AXI_AWADDR/AWID/AWLEN/AWSIZE/AWBURST/AWVALID`  out  ADDR_WIDTH/ID_WIDTH/8/3/2/1  write address
- `M_AXI_AWREADY`  in  1
- `M_AXI_WDATA/WSTRB/WLAST/WVALID`  out  DATA_WIDTH/STRB_WIDTH/1/1  write data
- `M_AXI_WREADY`  in  1
- `M_AXI_BID/BRESP/BVALID`  in  ID_WIDTH/2/1  write response
- `M_AXI_BREADY`  out  1
- `busy`  out  1  FSM not in IDLE
- `err`  out  1  sticky; set by any BRESP != 2'b00
- `sent_count`  out  32  beats with completed B responses; wraps modulo 2^32

## Operation
- **FSM states:** IDLE, ADDR, DATA, RESP.
- **IDLE → ADDR:** on a launch condition.
  - Launch conditions: `count >= MAX_BURST`, or `flush & count > 0`, or an auto-flush.
  - Beats per burst: `beats = min(count, MAX_BURST, (BASE_ADDR+ADDR_SPAN-addr)/STRB_WIDTH)`. A burst never crosses the window end.
  - At launch, latch `beats`, set AWLEN = beats-1, AWADDR = the current `addr`, AWSIZE = log2(STRB_WIDTH), AWBURST = 2'b01, AWID = AXI_ID.
- **ADDR:** AWVALID held high with stable fields until AWREADY. On the handshake, go to DATA.
- **DATA:**
  - WDATA is the FIFO head; WSTRB is all ones.
  - WLAST is high on beat `beats-1` only.
  - Each WVALID&WREADY pops one entry. After the last beat, go to RESP.
- **RESP:**
  - BREADY is high. On BVALID: if BRESP != 0, set `err`. Add `beats` to `sent_count`.
  - Advance `addr += beats*STRB_WIDTH`, wrapping to BASE_ADDR when the result equals BASE_ADDR+ADDR_SPAN. Return to IDLE.
- BID is not checked.
- The FIFO accepts pushes in every state. A push and a pop in the same cycle leave `count` unchanged.
- The burst size is frozen at launch. Entries pushed afterwards go to later bursts.
- `flush` is level-sensitive and sampled only in IDLE.

## Timing
- **Reset (async):**
  - All AXI valids, BREADY, `busy`, `err`, `sent_count` = 0; AWADDR = BASE_ADDR; other AXI outputs = 0.
  - FIFO is emptied; `addr` = BASE_ADDR; FSM = IDLE.
  - `inst_ready` = 1 (FIFO empty).
  - Asserting reset mid-burst abandons the transaction immediately.
- All outputs are registered except `inst_ready` (= !full), WDATA (FIFO head) and WLAST (beat compare).
- **Latency:**
  - Push at edge N, with the launch condition met → AWVALID high after edge N+1.
  - AW handshake at edge M → WVALID high after edge M.
  - With WREADY held high, beats stream at 1 per cycle.
  - Last W handshake at edge K → BREADY high after edge K.
  - B handshake at edge R → IDLE after R; the next AWVALID is no earlier than after edge R+1.
- Valid signals never drop without their handshake (AXI rule).
- **Full FIFO:** `inst_ready` = 0. A pop in the same cycle does not re-open `inst_ready` until the next cycle.

## Configuration
- `INST_AXI_WRITER_AUTOFLUSH_EN`
  - **Defined:** a counter clears on every push or launch and increments while in IDLE with `count > 0`. When it reaches TIMEOUT, a partial burst launches as if `flush` were high.
  - **Undefined:** the counter is not built. Partial bursts launch only on `flush`, and `TIMEOUT` is ignored.

## Test plan
- **Single instruction:** push 64'hDEADBEEF_DEADBEEF, pulse `flush`, slave always ready, BRESP=0.
  - One burst: AWADDR=0, AWLEN=0, AWID=1, WLAST=1 on the only beat.
  - `sent_count`=1, `err`=0.
- **Full burst:** push 64'hA5A5A5A5_00000000+i for i=0..3.
  - AWLEN=3 at AWADDR=0; WDATA in order; WLAST on beat 3.
  - The next burst's AWADDR=0x20.
- **Backpressure:** AWREADY delayed 3 cycles, WREADY toggling every cycle, BVALID delayed 5 cycles.
  - AWVALID/WVALID and their fields stay stable until each handshake.
  - No beat is lost or duplicated.
- **Window wrap:** start at addr 0x70, push 4 entries.
  - First burst: AWADDR=0x70, AWLEN=1.
  - Second burst: AWADDR=0x00, AWLEN=1.
- **FIFO full plus error:** push 17 entries with AWREADY stalled.
  - `inst_ready`=0 after 16 pushes.
  - Return BRESP=2'b10 → `err`=1 and remains 1.
- **Reset mid-burst:** assert `rst_n`=0 during DATA.
  - All valids drop immediately; `busy`=0, `sent_count`=0.
  - After release, the next burst starts at AWADDR=0.
